// File: rtl/trade_pkg.sv
// Shared price formats for the trading datapath: 10.6 unsigned prices and
// their full-width squares.
package trade_pkg;

    localparam int DATA_WIDTH   = 16;
    localparam int INTEGER_BITS = 10;
    localparam int FRAC_BITS    = DATA_WIDTH - INTEGER_BITS;

    typedef logic [DATA_WIDTH-1:0]   price_t;
    typedef logic [2*DATA_WIDTH-1:0] sq_t;

endpackage

// File: rtl/sample_ring.sv
// N-entry sample history. The entry at wr_ptr is the oldest sample and is read
// combinationally, so it can be evicted in the same cycle that it is overwritten.
module sample_ring #(
    parameter int data_width  = 16,
    parameter int log2_window = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  wr_en,
    input  logic [data_width-1:0] wr_data,
    output logic [data_width-1:0] oldest
);

    localparam int N = 1 << log2_window;

    logic [data_width-1:0]  ring_q [N];
    logic [data_width-1:0]  ring_d [N];
    logic [log2_window-1:0] wr_ptr_q;
    logic [log2_window-1:0] wr_ptr_d;

    always_comb begin
        ring_d   = ring_q;
        wr_ptr_d = wr_ptr_q;
        if (clr) begin
            for (int i = 0; i < N; i++) begin
                ring_d[i] = '0;
            end
            wr_ptr_d = '0;
        end else if (wr_en) begin
            ring_d[wr_ptr_q] = wr_data;
            wr_ptr_d         = wr_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                ring_q[i] <= '0;
            end
            wr_ptr_q <= '0;
        end else begin
            ring_q   <= ring_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    assign oldest = ring_q[wr_ptr_q];

endmodule

// File: rtl/rolling_stats.sv
// Sliding-window mean and mean-of-squares over the last 2^log2_window prices,
// registered one cycle after each accepted sample.
module rolling_stats
    import trade_pkg::*;
#(
    parameter int data_width   = DATA_WIDTH,
    parameter int integer_bits = INTEGER_BITS,
    parameter int log2_window  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    price_valid,
    input  logic [data_width-1:0]   price,
    input  logic                    flush,
    output logic [data_width-1:0]   current_data,
    output logic [data_width-1:0]   N_mean,
    output logic [2*data_width-1:0] N_sqr_mean,
    output logic                    data_valid_pre,
    output logic                    window_full
);

    localparam int SUM_W = data_width + log2_window;
    localparam int SQ_W  = 2 * data_width + log2_window;
    localparam logic [log2_window:0] WIN_N = {1'b1, {log2_window{1'b0}}};

    if (log2_window < 1 || log2_window > 6 || integer_bits > data_width) begin : g_bad_param
        $error("rolling_stats: unsupported parameter combination");
    end

    // Interface: a sample is taken on every cycle with price_valid=1 and flush=0;
    // there is no ready. data_valid_pre is a one-cycle strobe the consumer must take.
    logic                    accept;
    logic [data_width-1:0]   old;

    logic [SUM_W-1:0]        sum_q, sum_d;
    logic [SQ_W-1:0]         sq_sum_q, sq_sum_d;
    logic [log2_window:0]    fill_cnt_q, fill_cnt_d;
    logic [data_width-1:0]   current_data_q, current_data_d;
    logic [data_width-1:0]   mean_q, mean_d;
    logic [2*data_width-1:0] sqr_mean_q, sqr_mean_d;
    logic                    data_valid_q, data_valid_d;
    logic                    window_full_q, window_full_d;

    assign accept = price_valid & ~flush;

    sample_ring #(
        .data_width (data_width),
        .log2_window(log2_window)
    ) u_ring (
        .clk    (clk),
        .rst    (rst),
        .clr    (flush),
        .wr_en  (accept),
        .wr_data(price),
        .oldest (old)
    );

    always_comb begin
        sum_d          = sum_q;
        sq_sum_d       = sq_sum_q;
        fill_cnt_d     = fill_cnt_q;
        current_data_d = current_data_q;
        mean_d         = mean_q;
        sqr_mean_d     = sqr_mean_q;
        data_valid_d   = 1'b0;
        window_full_d  = window_full_q;
        if (flush) begin
            sum_d          = '0;
            sq_sum_d       = '0;
            fill_cnt_d     = '0;
            current_data_d = '0;
            mean_d         = '0;
            sqr_mean_d     = '0;
            window_full_d  = 1'b0;
        end else if (accept) begin
            // Empty slots hold zero, so evicting them during warm-up is harmless.
            sum_d    = sum_q + SUM_W'(price) - SUM_W'(old);
            sq_sum_d = sq_sum_q + SQ_W'(price) * SQ_W'(price) - SQ_W'(old) * SQ_W'(old);
            if (fill_cnt_q != WIN_N) begin
                fill_cnt_d = fill_cnt_q + 1'b1;
            end
            current_data_d = price;
            mean_d         = sum_d[SUM_W-1:log2_window];
            sqr_mean_d     = sq_sum_d[SQ_W-1:log2_window];
            data_valid_d   = (fill_cnt_d == WIN_N);
            window_full_d  = (fill_cnt_d == WIN_N);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q          <= '0;
            sq_sum_q       <= '0;
            fill_cnt_q     <= '0;
            current_data_q <= '0;
            mean_q         <= '0;
            sqr_mean_q     <= '0;
            data_valid_q   <= 1'b0;
            window_full_q  <= 1'b0;
        end else begin
            sum_q          <= sum_d;
            sq_sum_q       <= sq_sum_d;
            fill_cnt_q     <= fill_cnt_d;
            current_data_q <= current_data_d;
            mean_q         <= mean_d;
            sqr_mean_q     <= sqr_mean_d;
            data_valid_q   <= data_valid_d;
            window_full_q  <= window_full_d;
        end
    end

    assign current_data   = current_data_q;
    assign N_mean         = mean_q;
    assign N_sqr_mean     = sqr_mean_q;
    assign data_valid_pre = data_valid_q;
    assign window_full    = window_full_q;

endmodule
